// File: rtl/mux_arb_nb_pkg.sv
// Shared constants and helpers for the mux_arb_nb arbitrated multiplexer.
package mux_arb_nb_pkg;

    localparam int CH_MIN = 2;
    localparam int CH_MAX = 16;

    // Width of an index into 'value' items, never narrower than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Low bit of word 'idx' in a flattened bus of 'width'-bit words.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_arbiter_nb.sv
// Combinational arbiter, zero latency: one-hot grant plus index, searching from PTR upward
// (round-robin) or from 0 (fixed priority). No state; it re-evaluates REQ every cycle.
module rr_arbiter_nb
    import mux_arb_nb_pkg::*;
#(
    parameter int CH = 4,
    parameter int RR = 1
) (
    input  logic [CH-1:0]        REQ,
    input  logic [clog2(CH)-1:0] PTR,
    output logic [CH-1:0]        GNT,
    output logic [clog2(CH)-1:0] GNT_IDX
);

    localparam int IW = clog2(CH);

    logic found;
    int   base;
    int   idx;

    always_comb begin
        GNT     = '0;
        GNT_IDX = '0;
        found   = 1'b0;
        idx     = 0;
        base    = (RR != 0) ? int'(PTR) : 0;
        // Walk priority order base, base+1, ... modulo CH; first requester wins.
        for (int k = 0; k < CH; k++) begin
            idx = base + k;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            if (!found && REQ[idx]) begin
                found        = 1'b1;
                GNT[idx]     = 1'b1;
                GNT_IDX      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_arb_nb.sv
// CH-to-1 arbitrated mux with a single output register: one cycle latency, one word per cycle.
// Grants only when the output slot is empty or draining this cycle; READY_IN low stalls everything.
module mux_arb_nb
    import mux_arb_nb_pkg::*;
#(
    parameter int n  = 8,
    parameter int CH = 4,
    parameter int RR = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [CH-1:0]        VALID_IN,
    input  logic [CH*n-1:0]      D_IN,
    output logic [CH-1:0]        READY_OUT,
    output logic [n-1:0]         D_OUT,
    output logic [clog2(CH)-1:0] SEL_OUT,
    output logic                 VALID_OUT,
    input  logic                 READY_IN
);

    localparam int IW = clog2(CH);

    logic [CH-1:0] gnt;
    logic [IW-1:0] gnt_idx;
    logic          slot_open;
    logic          in_xfer;
    logic          out_xfer;

    logic [n-1:0]  dat_q,   dat_d;
    logic [IW-1:0] sel_q,   sel_d;
    logic          vld_q,   vld_d;
    logic [IW-1:0] ptr_q,   ptr_d;

    rr_arbiter_nb #(
        .CH (CH),
        .RR (RR)
    ) u_arb (
        .REQ     (VALID_IN),
        .PTR     (ptr_q),
        .GNT     (gnt),
        .GNT_IDX (gnt_idx)
    );

    assign out_xfer  = vld_q & READY_IN;
    assign slot_open = ~vld_q | READY_IN;
    // Gating with RST keeps upstream from handing over a word that reset would drop.
    assign READY_OUT = (slot_open && !RST) ? gnt : '0;
    assign in_xfer   = |READY_OUT;

    always_comb begin
        dat_d = dat_q;
        sel_d = sel_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (in_xfer) begin
            dat_d = D_IN[slice_lo(int'(gnt_idx), n) +: n];
            sel_d = gnt_idx;
            vld_d = 1'b1;
            if (RR != 0) begin
                ptr_d = (gnt_idx == IW'(CH - 1)) ? '0 : IW'(int'(gnt_idx) + 1);
            end else begin
                ptr_d = '0;
            end
        end else if (out_xfer) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dat_q <= '0;
            sel_q <= '0;
            vld_q <= 1'b0;
            ptr_q <= '0;
        end else begin
            dat_q <= dat_d;
            sel_q <= sel_d;
            vld_q <= vld_d;
            ptr_q <= ptr_d;
        end
    end

    assign D_OUT     = dat_q;
    assign SEL_OUT   = sel_q;
    assign VALID_OUT = vld_q;

endmodule

// File: tb/tb_mux_arb_nb.sv
// Round-robin and fixed-priority instances share stimulus; a cycle model checks both every cycle.
module tb_mux_arb_nb;

    localparam int N  = 8;
    localparam int CH = 4;

    logic          clk;
    logic          rst;
    logic [CH-1:0] valid_in;
    logic [CH*N-1:0] d_in;
    logic          ready_in;

    logic [CH-1:0] rdy_rr, rdy_fp;
    logic [N-1:0]  dout_rr, dout_fp;
    logic [1:0]    sel_rr, sel_fp;
    logic          vout_rr, vout_fp;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;

    mux_arb_nb #(.n(N), .CH(CH), .RR(1)) dut (
        .CLK(clk), .RST(rst), .VALID_IN(valid_in), .D_IN(d_in),
        .READY_OUT(rdy_rr), .D_OUT(dout_rr), .SEL_OUT(sel_rr),
        .VALID_OUT(vout_rr), .READY_IN(ready_in)
    );

    mux_arb_nb #(.n(N), .CH(CH), .RR(0)) dut_fp (
        .CLK(clk), .RST(rst), .VALID_IN(valid_in), .D_IN(d_in),
        .READY_OUT(rdy_fp), .D_OUT(dout_fp), .SEL_OUT(sel_fp),
        .VALID_OUT(vout_fp), .READY_IN(ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference state per instance: [0] round-robin, [1] fixed priority.
    int m_ptr [2];
    int m_v   [2];
    int m_d   [2];
    int m_sel [2];

    function automatic int winner(input logic [CH-1:0] req, input int start);
        for (int k = 0; k < CH; k++) begin
            if (req[(start + k) % CH]) return (start + k) % CH;
        end
        return -1;
    endfunction

    function automatic int exp_grant(input int m);
        if (rst) return -1;
        if (m_v[m] != 0 && !ready_in) return -1;
        return winner(valid_in, m_ptr[m]);
    endfunction

    function automatic logic [CH-1:0] onehot(input int w);
        logic [CH-1:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0; m_v[m] = 0; m_d[m] = 0; m_sel[m] = 0;
        end
        forever begin
            @(negedge clk);
            if (started) begin
                chk("rr_ready", rdy_rr, onehot(exp_grant(0)));
                chk("rr_valid", vout_rr, m_v[0]);
                chk("rr_dout", dout_rr, m_d[0]);
                chk("rr_sel", sel_rr, m_sel[0]);
                chk("fp_ready", rdy_fp, onehot(exp_grant(1)));
                chk("fp_valid", vout_fp, m_v[1]);
                chk("fp_dout", dout_fp, m_d[1]);
                chk("fp_sel", sel_fp, m_sel[1]);
            end
            @(posedge clk);
            for (int m = 0; m < 2; m++) begin
                int w;
                w = exp_grant(m);
                if (rst) begin
                    m_ptr[m] = 0; m_v[m] = 0; m_d[m] = 0; m_sel[m] = 0;
                end else if (w >= 0) begin
                    m_v[m]   = 1;
                    m_d[m]   = int'(d_in[w*N +: N]);
                    m_sel[m] = w;
                    m_ptr[m] = (m == 0) ? (w + 1) % CH : 0;
                end else if (m_v[m] != 0 && ready_in) begin
                    m_v[m] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq_a [5];
        seq_a[0] = 8'hA0; seq_a[1] = 8'hA1; seq_a[2] = 8'hA2; seq_a[3] = 8'hA3; seq_a[4] = 8'hA0;

        rst = 1'b1; valid_in = '0; ready_in = 1'b1;
        d_in = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        tick(); tick();
        rst = 1'b0;
        started = 1;
        @(negedge clk);
        chk("reset_valid", vout_rr, 0);
        chk("reset_sel", sel_rr, 0);
        chk("reset_dout", dout_rr, 0);

        // Full request set, free-running downstream.
        @(posedge clk); #1;
        valid_in = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_seq_sel", sel_rr, k % 4);
            chk("rr_seq_dout", dout_rr, seq_a[k]);
            chk("fp_seq_sel", sel_fp, 0);
            chk("fp_seq_dout", dout_fp, 8'hA0);
            chk("fp_seq_ready", rdy_fp, 4'b0001);
            tick();
        end

        // Advance to SEL_OUT=2 (pointer 3), then stall.
        tick();
        ready_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_sel", sel_rr, 2);
            chk("stall_dout", dout_rr, 8'hA2);
            chk("stall_valid", vout_rr, 1);
            chk("stall_ready", rdy_rr, 0);
            tick();
        end

        // Pointer at 3 wraps to channel 0, then channel 2.
        valid_in = 4'b0101; ready_in = 1'b1;
        @(negedge clk);
        chk("wrap_ready0", rdy_rr, 4'b0001);
        tick();
        @(negedge clk);
        chk("wrap_sel0", sel_rr, 0);
        chk("wrap_ready2", rdy_rr, 4'b0100);
        tick();
        @(negedge clk);
        chk("wrap_sel2", sel_rr, 2);

        // Grant channel 1 (pointer -> 2), then reset mid-stream.
        valid_in = 4'b0010;
        tick();
        rst = 1'b1; valid_in = 4'b1111;
        @(negedge clk);
        chk("rst_ready", rdy_rr, 0);
        chk("rst_ready_fp", rdy_fp, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_valid", vout_rr, 0);
        chk("postrst_dout", dout_rr, 0);
        chk("postrst_sel", sel_rr, 0);
        chk("postrst_ready", rdy_rr, 4'b0001);
        tick();
        @(negedge clk);
        chk("postrst_first_sel", sel_rr, 0);

        // Drain, then idle.
        valid_in = '0;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_valid", vout_rr, 0);
            chk("idle_ready", rdy_rr, 0);
            tick();
        end

        // Random traffic with stalls and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            valid_in = CH'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) valid_in = '0;
            d_in     = $urandom;
            ready_in = ($urandom_range(0, 9) < 7);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_arb_nb.md
MUX_ARB_NB -- requirements
Module: mux_arb_nb

Interface
REQ-001 Parameter n, default 8: data width per channel in bits.
REQ-002 Parameter CH, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter RR, default 1: 1 = round-robin arbitration, 0 = fixed priority with the lowest index winning.
REQ-004 CLK  input  1  sole clock; every state element updates on its rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 VALID_IN  input  CH  per-channel request; bit i means D_IN word i is valid.
REQ-007 D_IN  input  CH*n  flattened channel data; channel i occupies bits [i*n+n-1 : i*n].
REQ-008 READY_OUT  output  CH  per-channel grant; combinational, at most one bit set.
REQ-009 D_OUT  output  n  registered output data.
REQ-010 SEL_OUT  output  clog2(CH)  registered index of the channel whose word sits in D_OUT.
REQ-011 VALID_OUT  output  1  registered; D_OUT and SEL_OUT hold an unconsumed word.
REQ-012 READY_IN  input  1  downstream is able to accept D_OUT.

Function
REQ-013 Input transfer on channel i SHALL occur in a cycle where VALID_IN[i] and READY_OUT[i] are both 1.
REQ-014 Output transfer SHALL occur in a cycle where VALID_OUT and READY_IN are both 1.
REQ-015 Slot open condition: !VALID_OUT, or an output transfer in the same cycle.
REQ-016 READY_OUT[g] SHALL be 1 only when the slot is open and g is the arbiter winner among set VALID_IN bits; all other READY_OUT bits SHALL be 0.
REQ-017 READY_OUT SHALL be all-zero when VALID_IN is all-zero.
REQ-018 Pass-through: an input transfer at cycle t SHALL make D_OUT = D_IN[g], SEL_OUT = g and VALID_OUT = 1 at cycle t+1, for one cycle of latency.
REQ-019 Simultaneous output and input transfer SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-020 An output transfer with no input transfer SHALL clear VALID_OUT; D_OUT and SEL_OUT SHALL hold their last values.
REQ-021 With VALID_OUT = 1 and READY_IN = 0, D_OUT, SEL_OUT and VALID_OUT SHALL remain stable.
REQ-022 Round-robin mode: a pointer PTR (clog2(CH) bits) gives the highest-priority channel. Priority then descends PTR, PTR+1, ... modulo CH.
REQ-023 After an input transfer on channel g, PTR SHALL become (g+1) mod CH, wrapping from CH-1 to 0. PTR SHALL NOT change in cycles without an input transfer.
REQ-024 Fixed mode: PTR is unused and held at 0, so the lowest set index always wins.
REQ-025 An upstream channel SHALL be able to withdraw VALID_IN before it is granted; the arbiter re-evaluates every cycle and holds no stale grant.
REQ-026 A granted word is consumed in one cycle; no channel keeps the grant across cycles unless it wins again.

Reset
REQ-027 While RST = 1 at a rising edge: VALID_OUT = 0, D_OUT = 0, SEL_OUT = 0, PTR = 0.
REQ-028 READY_OUT SHALL be all-zero during any cycle with RST = 1, so no transfer is accepted.
REQ-029 Reset asserted mid-stream SHALL discard the held word; the first grant after reset follows PTR = 0.

Structure
REQ-030 The clog2 constant function and the flattened-bus slice width SHALL live in the shared OTTER package/header, alongside other common constants.
REQ-031 Arbitration SHALL be a separate combinational sub-module, rr_arbiter_nb (parameters CH and RR; inputs REQ and PTR; outputs one-hot GNT and binary GNT_IDX).
REQ-032 mux_arb_nb SHALL contain the output register, PTR register, slot-open logic and data selection only.

Verification
REQ-033 CH=4, n=8, RR=1, READY_IN=1, VALID_IN=4'b1111, D_IN words 8'hA0..8'hA3 -> SEL_OUT sequence 0,1,2,3,0 on consecutive cycles; D_OUT follows A0,A1,A2,A3,A0.
REQ-034 Same setup with RR=0 -> SEL_OUT held at 0 and D_OUT = 8'hA0 every cycle; READY_OUT = 4'b0001 throughout.
REQ-035 Word latched with SEL_OUT=2, then READY_IN=0 for 5 cycles with VALID_IN=4'b1111 -> D_OUT, SEL_OUT and VALID_OUT stable; READY_OUT = 0; PTR unchanged at 3.
REQ-036 PTR=3, VALID_IN=4'b0101 -> channel 0 granted (wrap), then PTR=1 and channel 2 granted next.
REQ-037 RST pulsed for 1 cycle while VALID_OUT=1 and PTR=2 -> next cycle VALID_OUT=0, D_OUT=0, SEL_OUT=0; the first subsequent grant with VALID_IN=4'b1111 goes to channel 0.
REQ-038 VALID_IN=0 for 10 cycles after a drain -> VALID_OUT=0 and READY_OUT=0 throughout.
